// File: rtl/ram_access_pkg.sv
// Shared types and helpers for the Ram access controller.
// Little-endian throughout: byte 0 of a word is bits [7:0].
package ram_access_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
    typedef enum logic {SZ_BYTE = 1'b0, SZ_WORD = 1'b1} size_e;

    typedef struct packed {
        logic              we;
        size_e             size;
        logic              sgn;
        logic [WORD_W-1:0] wdata;
    } req_t;

    function automatic logic [WORD_W-1:0] extend_byte(input logic [BYTE_W-1:0] b, input logic sgn);
        return sgn ? {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b} : {{(WORD_W-BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper: inserts a byte into lane ins_sel_i of one word and
// extracts lane ext_sel_i of another word.
module byte_lane_merge
    import ram_access_pkg::*;
(
    input  logic [NUM_LANES-1:0][BYTE_W-1:0] ins_word_i,
    input  logic [BYTE_W-1:0]                ins_byte_i,
    input  logic [1:0]                       ins_sel_i,
    input  logic [NUM_LANES-1:0][BYTE_W-1:0] ext_word_i,
    input  logic [1:0]                       ext_sel_i,
    output logic [NUM_LANES-1:0][BYTE_W-1:0] ins_word_o,
    output logic [BYTE_W-1:0]                ext_byte_o
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign ins_word_o[i] = (ins_sel_i == 2'(i)) ? ins_byte_i : ins_word_i[i];
    end

    assign ext_byte_o = ext_word_i[ext_sel_i];

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store front end for the byte/word Ram: range check, unaligned word splitting into
// four byte cycles, byte-load extension, and one held response per request.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int G               = 18,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic          req_size_i,
    input  logic          req_signed_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [G-1:0]  ram_address_o,
    output logic [31:0]   ram_data_o,
    output logic          ram_en_o,
    output logic          ram_bytemode_o,
    input  logic [31:0]   ram_data_i
);

    state_t      state, state_nx;
    req_t        r_req;
    logic        r_err;
    logic [1:0]  k;
    logic [31:0] r_acc;

    logic [32:0] req_end;
    logic        out_of_range, unaligned, req_err;
    logic [31:0] merged_word;
    logic [7:0]  next_st_byte;
    logic [31:0] rsp_data;

    // 33-bit end address so the check cannot wrap for any G up to 32
    assign req_end      = {1'b0, req_addr_i} + (req_size_i ? 33'd3 : 33'd0);
    assign out_of_range = |(req_end >> G);
    assign unaligned    = req_size_i && (req_addr_i[1:0] != 2'b00);
    assign req_err      = out_of_range || (unaligned && !ALLOW_UNALIGNED);

    assign req_ready_o = (state == IDLE);

    byte_lane_merge u_merge (
        .ins_word_i (r_acc),
        .ins_byte_i (ram_data_i[7:0]),
        .ins_sel_i  (k),
        .ext_word_i (r_req.wdata),
        .ext_sel_i  (k + 2'd1),
        .ins_word_o (merged_word),
        .ext_byte_o (next_st_byte)
    );

    always_comb begin
        rsp_data = 32'd0;
        if (!r_err && !r_req.we)
            rsp_data = (r_req.size == SZ_BYTE) ? extend_byte(r_acc[7:0], r_req.sgn) : r_acc;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid_i) state_nx = req_err ? RESP : (unaligned ? SPLIT : ACCESS);
            ACCESS:  state_nx = RESP;
            SPLIT:   if (k == 2'd3) state_nx = RESP;
            RESP:    if (rsp_valid_o && rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= IDLE;
            r_req          <= '0;
            r_err          <= 1'b0;
            k              <= 2'd0;
            r_acc          <= 32'd0;
            rsp_valid_o    <= 1'b0;
            rsp_rdata_o    <= 32'd0;
            rsp_err_o      <= 1'b0;
            ram_address_o  <= '0;
            ram_data_o     <= 32'd0;
            ram_en_o       <= 1'b0;
            ram_bytemode_o <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid_i) begin
                    r_req <= '{we: req_we_i, size: size_e'(req_size_i), sgn: req_signed_i,
                               wdata: req_wdata_i};
                    r_err <= req_err;
                    k     <= 2'd0;
                    r_acc <= 32'd0;
                    // Ram pins are loaded only once the range check has passed
                    if (!req_err) begin
                        ram_address_o  <= req_addr_i[G-1:0];
                        ram_en_o       <= req_we_i;
                        ram_bytemode_o <= !req_size_i || unaligned;
                        ram_data_o     <= (req_size_i && !unaligned) ? req_wdata_i
                                                                     : {24'd0, req_wdata_i[7:0]};
                    end
                end
                ACCESS: begin
                    ram_en_o <= 1'b0;
                    r_acc    <= ram_data_i;
                end
                SPLIT: begin
                    r_acc <= merged_word;
                    k     <= k + 2'd1;
                    if (k == 2'd3) begin
                        ram_en_o <= 1'b0;
                    end else begin
                        ram_address_o <= ram_address_o + G'(1);
                        ram_data_o    <= {24'd0, next_st_byte};
                    end
                end
                RESP: begin
                    if (!rsp_valid_o) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= r_err;
                        rsp_rdata_o <= rsp_data;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
